// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issue/writeback controller for an 8-bit add/and/or ALU.
// Takes 32-bit instructions over valid/ready, reads operands from an internal
// register file, drives the ALU operand/select inputs, and writes the sampled
// ALU result back. Subtraction negates operand 2 here because the ALU only adds.
// Optional feature macro: ALU_ISSUE_SKID_EN adds a one-entry instruction buffer
// so an instruction can be accepted while the controller is busy.
module alu_issue_ctrl #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 8,
  parameter int ALU_WAIT = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [31:0]                 instr_in,
  input  logic                        instr_valid,
  output logic                        instr_ready,
  output logic [DATA_W-1:0]           alu_data1,
  output logic [DATA_W-1:0]           alu_data2,
  output logic [2:0]                  alu_select,
  input  logic [DATA_W-1:0]           alu_result,
  output logic                        wb_valid,
  output logic [$clog2(NUM_REGS)-1:0] wb_addr,
  output logic [DATA_W-1:0]           wb_data,
  output logic                        illegal_op,
  output logic                        busy,
  input  logic [$clog2(NUM_REGS)-1:0] dbg_addr,
  output logic [DATA_W-1:0]           dbg_data
);

  localparam int AW = $clog2(NUM_REGS);
  localparam int CW = (ALU_WAIT < 2) ? 1 : $clog2(ALU_WAIT + 1);
  localparam logic [CW-1:0] WAIT_LOAD = CW'(ALU_WAIT);

  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;

  localparam logic [2:0] SEL_PASS = 3'b000;
  localparam logic [2:0] SEL_ADD  = 3'b001;
  localparam logic [2:0] SEL_AND  = 3'b010;
  localparam logic [2:0] SEL_OR   = 3'b011;

  typedef enum logic [1:0] {IDLE, DECODE, EXEC} state_t;

  state_t              state_reg;
  logic [31:0]         instr_reg;
  logic [CW-1:0]       wait_cnt_reg;
  logic [DATA_W-1:0]   regfile_reg [NUM_REGS];
  logic [DATA_W-1:0]   alu_data1_reg;
  logic [DATA_W-1:0]   alu_data2_reg;
  logic [2:0]          alu_select_reg;
  logic                wb_valid_reg;
  logic [AW-1:0]       wb_addr_reg;
  logic [DATA_W-1:0]   wb_data_reg;
  logic                illegal_op_reg;

`ifdef ALU_ISSUE_SKID_EN
  logic                buf_valid_reg;
  logic [31:0]         buf_instr_reg;
`endif

  // Instruction fields of the instruction currently being worked on.
  logic [7:0]          opcode;
  logic [AW-1:0]       dest_idx;
  logic [AW-1:0]       src1_idx;
  logic [AW-1:0]       src2_idx;
  logic [7:0]          imm;
  logic [DATA_W-1:0]   src1_val;
  logic [DATA_W-1:0]   src2_val;
  logic                unused_instr_bits;

  assign opcode   = instr_reg[31:24];
  assign dest_idx = instr_reg[16 +: AW];
  assign src1_idx = instr_reg[8 +: AW];
  assign src2_idx = instr_reg[0 +: AW];
  assign imm      = instr_reg[7:0];
  assign src1_val = regfile_reg[src1_idx];
  assign src2_val = regfile_reg[src2_idx];
  assign unused_instr_bits = ^{instr_reg[23:19], instr_reg[15:11]};

  // Handshake and writeback qualifiers.
  logic                accept;
  logic                wb_fire;
  logic [NUM_REGS-1:0] rf_we;

  assign accept  = instr_valid && instr_ready;
  assign wb_fire = (state_reg == EXEC) && (wait_cnt_reg == CW'(1));

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_rf_we
      assign rf_we[gi] = wb_fire && (dest_idx == AW'(gi));
    end
  endgenerate

`ifdef ALU_ISSUE_SKID_EN
  assign instr_ready = !reset && !buf_valid_reg;
`else
  assign instr_ready = !reset && (state_reg == IDLE);
`endif

  assign busy       = (state_reg != IDLE);
  assign alu_data1  = alu_data1_reg;
  assign alu_data2  = alu_data2_reg;
  assign alu_select = alu_select_reg;
  assign wb_valid   = wb_valid_reg;
  assign wb_addr    = wb_addr_reg;
  assign wb_data    = wb_data_reg;
  assign illegal_op = illegal_op_reg;
  assign dbg_data   = regfile_reg[dbg_addr];

  // Operand selection for the instruction sitting in DECODE.
  logic                op_legal;
  logic [2:0]          alu_select_next;
  logic [DATA_W-1:0]   alu_data1_next;
  logic [DATA_W-1:0]   alu_data2_next;

  // Decode opcode into ALU select and operand values; unknown opcodes flagged illegal.
  always_comb begin
    op_legal        = 1'b1;
    alu_select_next = SEL_PASS;
    alu_data1_next  = '0;
    alu_data2_next  = '0;
    case (opcode)
      OP_LOADI: alu_data2_next = DATA_W'(imm);
      OP_MOV:   alu_data2_next = src2_val;
      OP_ADD: begin
        alu_select_next = SEL_ADD;
        alu_data1_next  = src1_val;
        alu_data2_next  = src2_val;
      end
      OP_SUB: begin
        alu_select_next = SEL_ADD;
        alu_data1_next  = src1_val;
        alu_data2_next  = ~src2_val + DATA_W'(1);
      end
      OP_AND: begin
        alu_select_next = SEL_AND;
        alu_data1_next  = src1_val;
        alu_data2_next  = src2_val;
      end
      OP_OR: begin
        alu_select_next = SEL_OR;
        alu_data1_next  = src1_val;
        alu_data2_next  = src2_val;
      end
      default: op_legal = 1'b0;
    endcase
  end

  // Register file: cleared on reset, written only on the writeback edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regfile_reg[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (rf_we[i]) regfile_reg[i] <= alu_result;
      end
    end
  end

  // Issue FSM with registered ALU, writeback and illegal-op outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      instr_reg      <= '0;
      wait_cnt_reg   <= '0;
      alu_data1_reg  <= '0;
      alu_data2_reg  <= '0;
      alu_select_reg <= '0;
      wb_valid_reg   <= 1'b0;
      wb_addr_reg    <= '0;
      wb_data_reg    <= '0;
      illegal_op_reg <= 1'b0;
`ifdef ALU_ISSUE_SKID_EN
      buf_valid_reg  <= 1'b0;
      buf_instr_reg  <= '0;
`endif
    end else begin
      wb_valid_reg   <= 1'b0;
      illegal_op_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
`ifdef ALU_ISSUE_SKID_EN
          if (buf_valid_reg) begin
            instr_reg     <= buf_instr_reg;
            buf_valid_reg <= 1'b0;
            state_reg     <= DECODE;
          end else
`endif
          if (accept) begin
            instr_reg <= instr_in;
            state_reg <= DECODE;
          end
        end
        DECODE: begin
          if (op_legal) begin
            alu_select_reg <= alu_select_next;
            alu_data1_reg  <= alu_data1_next;
            alu_data2_reg  <= alu_data2_next;
            wait_cnt_reg   <= WAIT_LOAD;
            state_reg      <= EXEC;
          end else begin
            illegal_op_reg <= 1'b1;
            state_reg      <= IDLE;
          end
        end
        EXEC: begin
          if (wb_fire) begin
            wb_valid_reg <= 1'b1;
            wb_addr_reg  <= dest_idx;
            wb_data_reg  <= alu_result;
`ifdef ALU_ISSUE_SKID_EN
            if (buf_valid_reg) begin
              instr_reg     <= buf_instr_reg;
              buf_valid_reg <= 1'b0;
              state_reg     <= DECODE;
            end else
`endif
            state_reg <= IDLE;
          end else begin
            wait_cnt_reg <= wait_cnt_reg - CW'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase
`ifdef ALU_ISSUE_SKID_EN
      // Anything accepted while busy parks in the buffer; accept implies the buffer is empty.
      if (accept && (state_reg != IDLE)) begin
        buf_instr_reg <= instr_in;
        buf_valid_reg <= 1'b1;
      end
`endif
    end
  end

endmodule
